// File: rtl/regfile_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arb_pkg
// Description : Shared CPU constants and types for the register-file
//               writeback arbiter: stamp, register-address and data widths,
//               the buffered entry layout and the arrival-age helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arb_pkg;

  localparam int unsigned c_STAMP_W = 3;
  localparam int unsigned c_REG_W   = 5;
  localparam int unsigned c_DATA_W  = 32;

  typedef struct packed {
    logic [c_STAMP_W-1:0] stamp;
    logic [c_REG_W-1:0]   rw;
    logic [c_DATA_W-1:0]  data;
  } wb_entry_t;

  // At most four entries are ever in flight, so a forward distance of 1..3
  // from stamp A to stamp B means A arrived first.
  function automatic logic a_is_older(input logic [c_STAMP_W-1:0] i_sa,
                                      input logic [c_STAMP_W-1:0] i_sb);
    logic [c_STAMP_W-1:0] w_diff;
    w_diff = i_sb - i_sa;
    return (w_diff >= c_STAMP_W'(1)) && (w_diff <= c_STAMP_W'(3));
  endfunction

endpackage : regfile_wb_arb_pkg
`default_nettype wire

// File: rtl/regfile_wb_arb_wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry writeback FIFO of {stamp, rw, data}. Slot 0 is
//               always the head; a pop shifts slot 1 down. No bypass: a
//               pushed entry is visible only after the clock edge.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_push, i_din  - write an entry (ignored when full)
//               i_pop          - drop the head (ignored when empty)
//               o_head         - slot 0 entry
//               o_rw1          - slot 1 destination register
//               o_count        - number of valid entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
  import regfile_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  wb_entry_t          i_din,
  input  logic               i_pop,
  output wb_entry_t          o_head,
  output logic [c_REG_W-1:0] o_rw1,
  output logic [1:0]         o_count
);

  localparam logic [1:0] c_FULL = 2'(DEPTH);

  wb_entry_t  r_ent0;
  wb_entry_t  r_ent1;
  logic [1:0] r_count;

  logic       w_do_push;
  logic       w_do_pop;
  logic [1:0] w_cnt_after_pop;

  assign w_do_pop        = i_pop && (r_count != 2'd0);
  assign w_do_push       = i_push && (r_count != c_FULL);
  assign w_cnt_after_pop = r_count - {1'b0, w_do_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      if (w_do_pop) begin
        r_ent0 <= r_ent1;
      end
      // The push slot is chosen after accounting for a same-cycle pop, so
      // the later assignment to r_ent0 overrides the shift when needed.
      if (w_do_push) begin
        if (w_cnt_after_pop == 2'd0) begin
          r_ent0 <= i_din;
        end else begin
          r_ent1 <= i_din;
        end
      end
      r_count <= w_cnt_after_pop + {1'b0, w_do_push};
    end
  end

  assign o_head  = r_ent0;
  assign o_rw1   = r_ent1.rw;
  assign o_count = r_count;

endmodule : wb_fifo2
`default_nettype wire

// File: rtl/regfile_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arb
// Description : Arbitrates two writeback sources (A: ALU, B: load/multi-cycle)
//               onto one register-file write port. Each source is buffered in
//               a 2-entry FIFO; same-register conflicts resolve by arrival
//               age, otherwise round-robin. Also answers a hazard query.
// Ports       : Clk, Rst_n                 - clock, async active-low reset
//               A_/B_valid, _ready, _rw, _data - source handshakes
//               WE, Rw, busW               - registered register-file write
//               Q_r, Q_busy                - pending-write hazard query
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                A_valid,
  output logic                A_ready,
  input  logic [c_REG_W-1:0]  A_rw,
  input  logic [c_DATA_W-1:0] A_data,
  input  logic                B_valid,
  output logic                B_ready,
  input  logic [c_REG_W-1:0]  B_rw,
  input  logic [c_DATA_W-1:0] B_data,
  output logic                WE,
  output logic [c_REG_W-1:0]  Rw,
  output logic [c_DATA_W-1:0] busW,
  input  logic [c_REG_W-1:0]  Q_r,
  output logic                Q_busy
);

  localparam logic [1:0] c_FULL = 2'(DEPTH);

  logic                 r_live;   // low through reset so ready stays low
  logic [c_STAMP_W-1:0] r_stamp;
  logic                 r_rr_b;   // 1: round-robin favours B next
  logic                 r_we;
  logic [c_REG_W-1:0]   r_rw;
  logic [c_DATA_W-1:0]  r_busw;

  logic                 w_acc_a, w_acc_b;
  wb_entry_t            w_din_a, w_din_b;
  wb_entry_t            w_head_a, w_head_b, w_grant;
  logic [c_REG_W-1:0]   w_rw1_a, w_rw1_b;
  logic [1:0]           w_cnt_a, w_cnt_b;
  logic                 w_has_a, w_has_b;
  logic                 w_pop_a, w_pop_b;
  logic                 w_hit;

  assign A_ready = r_live && (w_cnt_a != c_FULL);
  assign B_ready = r_live && (w_cnt_b != c_FULL);
  assign w_acc_a = A_valid && A_ready;
  assign w_acc_b = B_valid && B_ready;

  // Same-cycle acceptance: A takes the current stamp, B the next one.
  assign w_din_a = {r_stamp, A_rw, A_data};
  assign w_din_b = {r_stamp + c_STAMP_W'(w_acc_a), B_rw, B_data};

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo_a (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .i_push (w_acc_a),
    .i_din  (w_din_a),
    .i_pop  (w_pop_a),
    .o_head (w_head_a),
    .o_rw1  (w_rw1_a),
    .o_count(w_cnt_a)
  );

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo_b (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .i_push (w_acc_b),
    .i_din  (w_din_b),
    .i_pop  (w_pop_b),
    .o_head (w_head_b),
    .o_rw1  (w_rw1_b),
    .o_count(w_cnt_b)
  );

  assign w_has_a = (w_cnt_a != 2'd0);
  assign w_has_b = (w_cnt_b != 2'd0);

  always_comb begin
    w_pop_a = 1'b0;
    w_pop_b = 1'b0;
    if (w_has_a && w_has_b) begin
      if (w_head_a.rw == w_head_b.rw) begin
        w_pop_a = a_is_older(w_head_a.stamp, w_head_b.stamp);
      end else begin
        w_pop_a = !r_rr_b;
      end
      w_pop_b = !w_pop_a;
    end else begin
      w_pop_a = w_has_a;
      w_pop_b = w_has_b;
    end
    w_grant = w_pop_a ? w_head_a : w_head_b;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_live  <= 1'b0;
      r_stamp <= '0;
      r_rr_b  <= 1'b0;
      r_we    <= 1'b0;
      r_rw    <= '0;
      r_busw  <= '0;
    end else begin
      r_live  <= 1'b1;
      r_stamp <= r_stamp + c_STAMP_W'(w_acc_a) + c_STAMP_W'(w_acc_b);
      r_we    <= 1'b0;
      if (w_pop_a || w_pop_b) begin
        // A pop to r0 is still a grant for fairness but writes nothing.
        r_rr_b <= w_pop_a;
        if (w_grant.rw != '0) begin
          r_we   <= 1'b1;
          r_rw   <= w_grant.rw;
          r_busw <= w_grant.data;
        end
      end
    end
  end

  assign WE   = r_we;
  assign Rw   = r_rw;
  assign busW = r_busw;

  always_comb begin
    w_hit = 1'b0;
    if ((w_cnt_a != 2'd0) && (w_head_a.rw == Q_r)) w_hit = 1'b1;
    if ((w_cnt_a == 2'd2) && (w_rw1_a == Q_r))     w_hit = 1'b1;
    if ((w_cnt_b != 2'd0) && (w_head_b.rw == Q_r)) w_hit = 1'b1;
    if ((w_cnt_b == 2'd2) && (w_rw1_b == Q_r))     w_hit = 1'b1;
    if (r_we && (r_rw == Q_r))                     w_hit = 1'b1;
  end

  assign Q_busy = (Q_r != '0) && w_hit;

endmodule : regfile_wb_arb
`default_nettype wire

// File: tb/tb_regfile_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arb
// Description : Self-checking bench for regfile_wb_arb. A queue-based model
//               predicts the per-cycle write port and ready/hazard outputs;
//               a monitor compares the write port against predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arb;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        A_valid = 1'b0, B_valid = 1'b0;
  logic        A_ready, B_ready;
  logic [4:0]  A_rw = '0, B_rw = '0, Q_r = '0;
  logic [31:0] A_data = '0, B_data = '0;
  logic        WE, Q_busy;
  logic [4:0]  Rw;
  logic [31:0] busW;

  regfile_wb_arb #(.DEPTH(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_valid(A_valid), .A_ready(A_ready), .A_rw(A_rw), .A_data(A_data),
    .B_valid(B_valid), .B_ready(B_ready), .B_rw(B_rw), .B_data(B_data),
    .WE(WE), .Rw(Rw), .busW(busW), .Q_r(Q_r), .Q_busy(Q_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { int st; logic [4:0] rw; logic [31:0] d; } ent_t;
  typedef struct { logic we; logic [4:0] rw; logic [31:0] d; } out_t;

  ent_t qa[$], qb[$];
  out_t expq[$];
  bit          favor_a = 1'b1;
  int          m_stamp = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rw = '0;
  logic [31:0] m_d = '0;
  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); expq.delete();
    favor_a = 1'b1; m_stamp = 0; m_we = 1'b0; m_rw = '0; m_d = '0;
  endtask

  // One clock cycle: drive inputs, check ready/hazard, then predict the edge.
  task automatic cycle(input bit av, input logic [4:0] arw, input logic [31:0] ad,
                       input bit bv, input logic [4:0] brw, input logic [31:0] bd,
                       input logic [4:0] q, output bit acc_a, output bit acc_b);
    bit busy_exp, rdy_a, rdy_b, has_a, has_b, take_a;
    int diff;
    ent_t e;
    @(negedge Clk);
    A_valid = av; A_rw = arw; A_data = ad;
    B_valid = bv; B_rw = brw; B_data = bd;
    Q_r = q;
    #1;
    busy_exp = 1'b0;
    if (q != 0) begin
      foreach (qa[i]) if (qa[i].rw == q) busy_exp = 1'b1;
      foreach (qb[i]) if (qb[i].rw == q) busy_exp = 1'b1;
      if (m_we && m_rw == q) busy_exp = 1'b1;
    end
    check("q_busy", 64'(Q_busy), 64'(busy_exp));
    rdy_a = qa.size() < 2;
    rdy_b = qb.size() < 2;
    check("a_ready", 64'(A_ready), 64'(rdy_a));
    check("b_ready", 64'(B_ready), 64'(rdy_b));
    acc_a = av && rdy_a;
    acc_b = bv && rdy_b;
    has_a = qa.size() > 0;
    has_b = qb.size() > 0;
    take_a = has_a;
    if (has_a && has_b) begin
      if (qa[0].rw == qb[0].rw) begin
        diff = (qb[0].st - qa[0].st + 8) % 8;
        take_a = (diff >= 1) && (diff <= 3);
      end else begin
        take_a = favor_a;
      end
    end
    m_we = 1'b0;
    if (has_a || has_b) begin
      e = take_a ? qa.pop_front() : qb.pop_front();
      favor_a = !take_a;
      if (e.rw != 0) begin
        m_we = 1'b1; m_rw = e.rw; m_d = e.d;
      end
    end
    expq.push_back('{we: m_we, rw: m_rw, d: m_d});
    if (acc_a) begin qa.push_back('{st: m_stamp, rw: arw, d: ad}); m_stamp = (m_stamp + 1) % 8; end
    if (acc_b) begin qb.push_back('{st: m_stamp, rw: brw, d: bd}); m_stamp = (m_stamp + 1) % 8; end
  endtask

  task automatic idle(input int n);
    bit xa, xb;
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, '0, xa, xb);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0; A_valid = 1'b0; B_valid = 1'b0;
    #1;
    check("a_ready_rst", 64'(A_ready), 64'(0));
    check("b_ready_rst", 64'(B_ready), 64'(0));
    model_clear();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // Monitor: every post-reset edge has a predicted write-port state.
  initial begin
    out_t x;
    forever begin
      @(posedge Clk);
      #1;
      if (!Rst_n) begin
        check("we_rst", 64'(WE), 64'(0));
        check("rw_rst", 64'(Rw), 64'(0));
        check("busw_rst", 64'(busW), 64'(0));
      end else if (expq.size() > 0) begin
        x = expq.pop_front();
        check("we", 64'(WE), 64'(x.we));
        check("rw", 64'(Rw), 64'(x.rw));
        check("busw", 64'(busW), 64'(x.d));
      end
    end
  end

  initial begin
    bit aa, ab;
    logic [31:0] pend_d[$];
    int guard;
    do_reset();
    idle(1);
    // A alone: rw=5, 0x11
    cycle(1, 5'd5, 32'h11, 0, '0, '0, 5'd5, aa, ab);
    idle(3);
    // Same cycle A/B to r3: A first
    cycle(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, 5'd3, aa, ab);
    idle(4);
    // B one cycle before A, both to r7: B first
    cycle(0, '0, '0, 1, 5'd7, 32'hB7, 5'd7, aa, ab);
    cycle(1, 5'd7, 32'hA7, 0, '0, '0, 5'd7, aa, ab);
    idle(4);
    // Three back-to-back A offers against a flooding B
    pend_d = '{32'hA1, 32'hA2, 32'hA3};
    guard = 0;
    while (pend_d.size() > 0 && guard < 30) begin
      cycle(1, 5'd9, pend_d[0], 1, 5'd9, 32'hB0 + 32'(guard), 5'd9, aa, ab);
      if (aa) void'(pend_d.pop_front());
      guard++;
    end
    n_checks++;
    if (pend_d.size() == 0) n_pass++;
    else $display("FAIL a_offer_timeout: %0d offers left, required 0", pend_d.size());
    idle(6);
    // rw=0 consumed with no write
    cycle(1, 5'd0, 32'hDEAD, 0, '0, '0, 5'd0, aa, ab);
    idle(3);
    // Fill both FIFOs then reset mid-operation
    for (int i = 0; i < 4; i++) cycle(1, 5'd12, 32'(i), 1, 5'd13, 32'(100 + i), 5'd12, aa, ab);
    do_reset();
    for (int i = 0; i < 32; i++) cycle(0, '0, '0, 0, '0, '0, 5'(i), aa, ab);
    // Randomized traffic with frequent register collisions
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 60,
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
            $urandom,
            $urandom_range(0, 99) < 60,
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
            $urandom,
            ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
            aa, ab);
    end
    idle(8);
    @(posedge Clk);
    #2;
    check("scoreboard_drained", 64'(expq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_wb_arb
`default_nettype wire
